reg_share_arbiter: RTL and testbench
====================================

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of the shared register and of each requester data slice.
REQ-002 Parameter MAX_HOLD, default 4: maximum consecutive grants to one locked requester; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-005 req  input  4  write request, one bit per requester 0..3.
REQ-006 lock  input  4  burst-hold request, one bit per requester; meaningful only together with the matching req bit.
REQ-007 din  input  4*WIDTH  requester data; requester i drives din[i*WIDTH +: WIDTH].
REQ-008 q  output  WIDTH  shared register contents.
REQ-009 gnt  output  4  registered one-hot grant: the requester whose data was written into q at the last edge.
REQ-010 owner  output  2  binary index of the last granted requester.
REQ-011 valid  output  1  high for the cycle following any edge at which q was written.
REQ-012 busy  output  1  high while the FSM is in HOLD.

Function
REQ-013 The block SHALL time-share one WIDTH-bit register between 4 requesters; at most one write per edge.
REQ-014 The FSM SHALL have exactly two states: ARB and HOLD.
REQ-015 Round-robin pointer ptr (2 bits): the winner is the first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
REQ-016 ARB, req=0: q holds; gnt<=0; valid<=0; owner and ptr hold.
REQ-017 ARB, req!=0, winner w: q<=din slice w; gnt<=1<<w; owner<=w; valid<=1; ptr<=(w+1) mod 4.
REQ-018 Entry to HOLD: if lock[w]=1 and MAX_HOLD>1 at that edge, state<=HOLD and hold_cnt<=1; otherwise state stays ARB.
REQ-019 HOLD continues when req[owner]=1, lock[owner]=1 and hold_cnt<MAX_HOLD: q<=din slice owner; gnt held; valid<=1; hold_cnt increments; ptr unchanged.
REQ-020 HOLD exit: in any other HOLD case, the same edge SHALL apply the ARB rules of REQ-016..REQ-018. The previous owner therefore has lowest priority and wins again only if it is the sole requester.
REQ-021 Latency: data presented with a winning request at edge t SHALL appear on q, with the matching gnt and valid=1, immediately after edge t.
REQ-022 Requests and locks from non-winning requesters SHALL be ignored, with no effect on state.
REQ-023 gnt SHALL always be zero or one-hot.
REQ-024 busy SHALL equal (state==HOLD).
REQ-025 ptr SHALL wrap from 3 to 0.
REQ-026 hold_cnt SHALL never exceed MAX_HOLD. A burst SHALL comprise at most MAX_HOLD consecutive grants, counting the entry grant.

Reset
REQ-027 On an edge with rst=0: q<=0, gnt<=0, owner<=0, valid<=0, busy<=0, state<=ARB, ptr<=0, hold_cnt<=0. Inputs are ignored at that edge.
REQ-028 Reset asserted mid-burst SHALL abort the burst. The first post-reset arbitration SHALL start from ptr=0.

Verification
REQ-029 Reset then idle: rst=0 for 2 cycles, then rst=1 with req=0 -> q=0, gnt=0, valid=0, busy=0 every cycle.
REQ-030 Round-robin rotation: req=4'b1111, lock=0, din slices 0x10,0x11,0x12,0x13 -> gnt sequence 0001, 0010, 0100, 1000, 0001; q sequence 0x10, 0x11, 0x12, 0x13, 0x10; valid=1 throughout.
REQ-031 Locked burst, defaults: req=4'b0011, lock=4'b0001 held -> gnt=0001 for 4 cycles with busy=1 on cycles 1..4, then gnt=0010 with busy=0, then gnt=0001 again.
REQ-032 Early lock release: requester 2 locked alone; drop lock[2] after 2 grants while req[1]=1 -> next edge gnt=0010, owner=1, busy=0.
REQ-033 Reset mid-burst: during HOLD for owner 3 with q=0xA5, rst=0 for one edge -> q=0, gnt=0, busy=0. Then req=4'b1010 -> gnt=0010.
REQ-034 MAX_HOLD=1 build: lock=4'b1111 with req=4'b1111 -> busy stays 0 and grants rotate exactly as in REQ-030.

Source files
------------

// File: rtl/reg_share_arbiter.sv
// Time-shares one WIDTH-bit register between four requesters using a
// round-robin arbiter with optional bounded burst hold (lock).
module reg_share_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [3:0]           lock,
    input  logic [4*WIDTH-1:0]   din,
    output logic [WIDTH-1:0]     q,
    output logic [3:0]           gnt,
    output logic [1:0]           owner,
    output logic                 valid,
    output logic                 busy
);

    localparam int unsigned NREQ     = 4;
    localparam int unsigned CNT_W    = 4;
    localparam logic        CAN_HOLD = (MAX_HOLD > 1);
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         ptr, ptr_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic [3:0]         gnt_nxt;
    logic [1:0]         owner_nxt;
    logic               valid_nxt;
    logic               busy_nxt;

    logic [WIDTH-1:0]   slice [NREQ];
    logic [1:0]         win;
    logic [1:0]         idx;
    logic               found;
    logic               hold_go;

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign slice[i] = din[i*WIDTH +: WIDTH];
    end

    // State and output registers; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ARB;
            ptr      <= '0;
            hold_cnt <= '0;
            q        <= '0;
            gnt      <= '0;
            owner    <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            q        <= q_nxt;
            gnt      <= gnt_nxt;
            owner    <= owner_nxt;
            valid    <= valid_nxt;
            busy     <= busy_nxt;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        q_nxt        = q;
        gnt_nxt      = gnt;
        owner_nxt    = owner;
        valid_nxt    = 1'b0;
        win          = ptr;
        idx          = '0;
        found        = 1'b0;

        // Round-robin scan starting at ptr
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end

        hold_go = (state == HOLD) && req[owner] && lock[owner] &&
                  (hold_cnt < HOLD_LIMIT);

        if (hold_go) begin
            state_nxt    = HOLD;
            q_nxt        = slice[owner];
            valid_nxt    = 1'b1;
            hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end else if (found) begin
            q_nxt     = slice[win];
            gnt_nxt   = 4'b0001 << win;
            owner_nxt = win;
            valid_nxt = 1'b1;
            ptr_nxt   = win + 2'd1;
            if (lock[win] && CAN_HOLD) begin
                state_nxt    = HOLD;
                hold_cnt_nxt = CNT_W'(1);
            end else begin
                state_nxt    = ARB;
                hold_cnt_nxt = '0;
            end
        end else begin
            state_nxt    = ARB;
            gnt_nxt      = '0;
            hold_cnt_nxt = '0;
        end

        busy_nxt = (state_nxt == HOLD);
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter: table-driven vectors plus hand
// sequences, with expectations queued at drive time and popped after the edge.
module tb_reg_share_arbiter;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req;
    logic [3:0]     lock;
    logic [4*W-1:0] din;

    logic [W-1:0]   q0, q1;
    logic [3:0]     gnt0, gnt1;
    logic [1:0]     owner0, owner1;
    logic           valid0, valid1;
    logic           busy0, busy1;

    always #5 clk = ~clk;

    reg_share_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .din(din),
        .q(q0), .gnt(gnt0), .owner(owner0), .valid(valid0), .busy(busy0)
    );

    reg_share_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut_mh1 (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .din(din),
        .q(q1), .gnt(gnt1), .owner(owner1), .valid(valid1), .busy(busy1)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] din;
        logic        inst;
        logic [7:0]  q;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic        valid;
        logic        busy;
    } vec_t;

    typedef struct {
        int          id;
        logic        inst;
        logic [7:0]  q;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic        valid;
        logic        busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] D  = 32'h13121110;
    localparam logic [31:0] DA = 32'hA5121110;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                                input logic [31:0] d, input logic in,
                                input logic [7:0] eq, input logic [3:0] eg,
                                input logic [1:0] eo, input logic ev, input logic eb);
        vec_t v;
        v.rst = r; v.req = rq; v.lock = lk; v.din = d; v.inst = in;
        v.q = eq; v.gnt = eg; v.owner = eo; v.valid = ev; v.busy = eb;
        return v;
    endfunction

    task automatic cmp(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got output with no expectation queued");
        end else begin
            e = sb.pop_front();
            if (e.inst == 1'b0) begin
                cmp("q",     e.id, 32'(q0),     32'(e.q));
                cmp("gnt",   e.id, 32'(gnt0),   32'(e.gnt));
                cmp("owner", e.id, 32'(owner0), 32'(e.owner));
                cmp("valid", e.id, 32'(valid0), 32'(e.valid));
                cmp("busy",  e.id, 32'(busy0),  32'(e.busy));
            end else begin
                cmp("mh1_q",     e.id, 32'(q1),     32'(e.q));
                cmp("mh1_gnt",   e.id, 32'(gnt1),   32'(e.gnt));
                cmp("mh1_owner", e.id, 32'(owner1), 32'(e.owner));
                cmp("mh1_valid", e.id, 32'(valid1), 32'(e.valid));
                cmp("mh1_busy",  e.id, 32'(busy1),  32'(e.busy));
            end
        end
    endtask

    task automatic drive(input vec_t v, input int id);
        exp_t e;
        @(negedge clk);
        rst  = v.rst;
        req  = v.req;
        lock = v.lock;
        din  = v.din;
        e.id = id; e.inst = v.inst; e.q = v.q; e.gnt = v.gnt;
        e.owner = v.owner; e.valid = v.valid; e.busy = v.busy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        rst  = 1'b0;
        req  = '0;
        lock = '0;
        din  = '0;

        // Reset, then idle
        tbl.push_back(mk(0, 4'hF, 4'hF, D, 0, 8'h00, 4'h0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, D, 0, 8'h00, 4'h0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 4'h0, D, 0, 8'h00, 4'h0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 4'h0, D, 0, 8'h00, 4'h0, 2'd0, 0, 0));
        // Round-robin rotation with wrap, then idle holds q/owner
        tbl.push_back(mk(1, 4'hF, 4'h0, D, 0, 8'h10, 4'h1, 2'd0, 1, 0));
        tbl.push_back(mk(1, 4'hF, 4'h0, D, 0, 8'h11, 4'h2, 2'd1, 1, 0));
        tbl.push_back(mk(1, 4'hF, 4'h0, D, 0, 8'h12, 4'h4, 2'd2, 1, 0));
        tbl.push_back(mk(1, 4'hF, 4'h0, D, 0, 8'h13, 4'h8, 2'd3, 1, 0));
        tbl.push_back(mk(1, 4'hF, 4'h0, D, 0, 8'h10, 4'h1, 2'd0, 1, 0));
        tbl.push_back(mk(1, 4'h0, 4'h0, D, 0, 8'h10, 4'h0, 2'd0, 0, 0));
        // Locked burst capped at 4 grants, then rotate, then re-lock
        tbl.push_back(mk(0, 4'h0, 4'h0, D, 0, 8'h00, 4'h0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 4'h1, D, 0, 8'h10, 4'h1, 2'd0, 1, 1));
        tbl.push_back(mk(1, 4'h3, 4'h1, D, 0, 8'h10, 4'h1, 2'd0, 1, 1));
        tbl.push_back(mk(1, 4'h3, 4'h1, D, 0, 8'h10, 4'h1, 2'd0, 1, 1));
        tbl.push_back(mk(1, 4'h3, 4'h1, D, 0, 8'h10, 4'h1, 2'd0, 1, 1));
        tbl.push_back(mk(1, 4'h3, 4'h1, D, 0, 8'h11, 4'h2, 2'd1, 1, 0));
        tbl.push_back(mk(1, 4'h3, 4'h1, D, 0, 8'h10, 4'h1, 2'd0, 1, 1));
        // Owner drops req: burst ends; stray locks of losers have no effect
        tbl.push_back(mk(1, 4'h2, 4'h1, D, 0, 8'h11, 4'h2, 2'd1, 1, 0));
        tbl.push_back(mk(1, 4'hC, 4'h8, D, 0, 8'h12, 4'h4, 2'd2, 1, 0));
        tbl.push_back(mk(1, 4'hC, 4'h8, D, 0, 8'h13, 4'h8, 2'd3, 1, 1));
        tbl.push_back(mk(1, 4'h4, 4'h8, D, 0, 8'h12, 4'h4, 2'd2, 1, 0));
        // MAX_HOLD=1 build never holds
        tbl.push_back(mk(0, 4'h0, 4'h0, D, 1, 8'h00, 4'h0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 4'hF, 4'hF, D, 1, 8'h10, 4'h1, 2'd0, 1, 0));
        tbl.push_back(mk(1, 4'hF, 4'hF, D, 1, 8'h11, 4'h2, 2'd1, 1, 0));
        tbl.push_back(mk(1, 4'hF, 4'hF, D, 1, 8'h12, 4'h4, 2'd2, 1, 0));
        tbl.push_back(mk(1, 4'hF, 4'hF, D, 1, 8'h13, 4'h8, 2'd3, 1, 0));
        tbl.push_back(mk(1, 4'hF, 4'hF, D, 1, 8'h10, 4'h1, 2'd0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i], i);
        end

        // Early lock release hands over to the next requester
        drive(mk(0, 4'h0, 4'h0, D, 0, 8'h00, 4'h0, 2'd0, 0, 0), 100);
        drive(mk(1, 4'h4, 4'h4, D, 0, 8'h12, 4'h4, 2'd2, 1, 1), 101);
        drive(mk(1, 4'h4, 4'h4, D, 0, 8'h12, 4'h4, 2'd2, 1, 1), 102);
        drive(mk(1, 4'h6, 4'h0, D, 0, 8'h11, 4'h2, 2'd1, 1, 0), 103);

        // Reset mid-burst aborts it and restarts arbitration at 0
        drive(mk(1, 4'h8, 4'h8, DA, 0, 8'hA5, 4'h8, 2'd3, 1, 1), 110);
        drive(mk(1, 4'h8, 4'h8, DA, 0, 8'hA5, 4'h8, 2'd3, 1, 1), 111);
        drive(mk(0, 4'h8, 4'h8, DA, 0, 8'h00, 4'h0, 2'd0, 0, 0), 112);
        drive(mk(1, 4'hA, 4'h0, D,  0, 8'h11, 4'h2, 2'd1, 1, 0), 113);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
